// File: rtl/rf_access_if.sv
// Requester and register-file side signals of the register-file access arbiter.
// Each signal name carries its direction as seen from the arbiter.
interface rf_access_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  req0_i;
  logic                  req1_i;
  logic                  we0_i;
  logic                  we1_i;
  logic [ADDR_WIDTH-1:0] addr0_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic                  gnt0_o;
  logic                  gnt1_o;
  logic                  done0_o;
  logic                  done1_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rf_read_o;
  logic                  rf_write_o;
  logic [ADDR_WIDTH-1:0] rf_addr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic [DATA_WIDTH-1:0] rf_rdata_i;

  // Arbiter side.
  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  rf_rdata_i,
    output gnt0_o, gnt1_o, done0_o, done1_o, rdata_o,
    output rf_read_o, rf_write_o, rf_addr_o, rf_wdata_o
  );

  // Requesters plus register-file model.
  modport master (
    output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output rf_rdata_i,
    input  gnt0_o, gnt1_o, done0_o, done1_o, rdata_o,
    input  rf_read_o, rf_write_o, rf_addr_o, rf_wdata_o
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing the register-file access port between two requesters.
// Every grant runs one fixed-length read or write; all outputs are registered.
module rf_access_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ACC_CYCLES = 2
) (
  input logic        clk_i,
  input logic        rst_i,
  rf_access_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc_cycles
    $error("rf_access_arbiter: ACC_CYCLES must be within 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic                  last_q,     last_d;
  logic                  win_q,      win_d;
  logic                  we_q,       we_d;
  logic                  gnt0_q,     gnt0_d;
  logic                  gnt1_q,     gnt1_d;
  logic                  done0_q,    done0_d;
  logic                  done1_q,    done1_d;
  logic                  rf_read_q,  rf_read_d;
  logic                  rf_write_q, rf_write_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q,  rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic                  sel;

  // State and output registers; reset also aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rf_read_q  <= 1'b0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      win_q      <= win_d;
      we_q       <= we_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      rf_read_q  <= rf_read_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, count the access, pulse DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    win_d      = win_q;
    we_d       = we_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    rf_read_d  = rf_read_q;
    rf_write_d = rf_write_q;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    rdata_d    = rdata_q;
    sel        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rf_read_d  = 1'b0;
        rf_write_d = 1'b0;
        if (bus.req0_i || bus.req1_i) begin
          // Contention goes to whoever was not served last.
          sel        = (bus.req0_i && bus.req1_i) ? ~last_q : bus.req1_i;
          win_d      = sel;
          we_d       = sel ? bus.we1_i    : bus.we0_i;
          rf_addr_d  = sel ? bus.addr1_i  : bus.addr0_i;
          rf_wdata_d = sel ? bus.wdata1_i : bus.wdata0_i;
          rf_read_d  = ~we_d;
          rf_write_d = we_d;
          gnt0_d     = ~sel;
          gnt1_d     = sel;
          cnt_d      = CNT_W'(ACC_CYCLES - 1);
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = bus.rf_rdata_i;
          end
          rf_read_d  = 1'b0;
          rf_write_d = 1'b0;
          done0_d    = ~win_q;
          done1_d    = win_q;
          last_d     = win_q;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt0_o     = gnt0_q;
  assign bus.gnt1_o     = gnt1_q;
  assign bus.done0_o    = done0_q;
  assign bus.done1_o    = done1_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.rf_read_o  = rf_read_q;
  assign bus.rf_write_o = rf_write_q;
  assign bus.rf_addr_o  = rf_addr_q;
  assign bus.rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rf_access_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int          ACC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_access_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rf_access_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ACC_CYCLES(ACC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Register file: combinational read, write on the strobe edge.
  logic [DW-1:0] rf_mem [32];
  assign bus.rf_rdata_i = rf_mem[bus.rf_addr_o];
  always @(posedge clk) if (bus.rf_write_o === 1'b1) rf_mem[bus.rf_addr_o] <= bus.rf_wdata_o;

  // Transaction model: a grant at edge t0 occupies edges t0..t0+ACC+1.
  bit            m_active = 1'b0;
  int            m_t0     = 0;
  int            m_win    = 0;
  int            m_last   = 1;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic [DW-1:0] m_rdata  = '0;
  logic [DW-1:0] m_mem [32];

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (rst) begin
      m_active = 1'b0;
      m_last   = 1;
      m_addr   = '0;
      m_wdata  = '0;
      m_rdata  = '0;
    end else if (!m_active) begin
      if (bus.req0_i || bus.req1_i) begin
        m_win    = (bus.req0_i && bus.req1_i) ? (1 - m_last) : (bus.req1_i ? 1 : 0);
        m_we     = (m_win == 1) ? bus.we1_i    : bus.we0_i;
        m_addr   = (m_win == 1) ? bus.addr1_i  : bus.addr0_i;
        m_wdata  = (m_win == 1) ? bus.wdata1_i : bus.wdata0_i;
        m_t0     = cyc;
        m_active = 1'b1;
      end
    end else begin
      if (cyc == m_t0 + ACC) begin
        if (m_we) m_mem[m_addr] = m_wdata;
        else      m_rdata = m_mem[m_addr];
        m_last = m_win;
      end
      if (cyc == m_t0 + ACC + 1) m_active = 1'b0;
    end
  end

  int gid_q [$];
  int gcyc_q [$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic e_gnt, e_strobe, e_done;
    if (started) begin
      e_gnt    = m_active && (cyc == m_t0);
      e_strobe = m_active && ((cyc - m_t0) < ACC);
      e_done   = m_active && (cyc == m_t0 + ACC);
      chk("gnt0",     32'(bus.gnt0_o),     32'(e_gnt  && m_win == 0));
      chk("gnt1",     32'(bus.gnt1_o),     32'(e_gnt  && m_win == 1));
      chk("done0",    32'(bus.done0_o),    32'(e_done && m_win == 0));
      chk("done1",    32'(bus.done1_o),    32'(e_done && m_win == 1));
      chk("rf_read",  32'(bus.rf_read_o),  32'(e_strobe && !m_we));
      chk("rf_write", 32'(bus.rf_write_o), 32'(e_strobe && m_we));
      chk("rf_addr",  32'(bus.rf_addr_o),  32'(m_addr));
      chk("rf_wdata", bus.rf_wdata_o,      m_wdata);
      chk("rdata",    bus.rdata_o,         m_rdata);
      if (bus.gnt0_o === 1'b1) begin gid_q.push_back(0); gcyc_q.push_back(cyc); end
      if (bus.gnt1_o === 1'b1) begin gid_q.push_back(1); gcyc_q.push_back(cyc); end
    end
  end

  always @(posedge clk) begin
    if (cyc > 3000) begin
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "bench timeout");
    end
  end

  task automatic set_req(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      bus.we0_i = we; bus.addr0_i = a; bus.wdata0_i = d; bus.req0_i = 1'b1;
    end else begin
      bus.we1_i = we; bus.addr1_i = a; bus.wdata1_i = d; bus.req1_i = 1'b1;
    end
  endtask

  task automatic wait_gnt(input int id, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((id == 0 && bus.gnt0_o === 1'b1) || (id == 1 && bus.gnt1_o === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("gnt_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_any_gnt(output logic g0, output logic g1);
    bit ok = 1'b0;
    g0 = 1'b0; g1 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.gnt0_o === 1'b1 || bus.gnt1_o === 1'b1) begin
        g0 = bus.gnt0_o; g1 = bus.gnt1_o; ok = 1'b1;
        break;
      end
    end
    chk("any_gnt_seen", 32'(ok), 32'd1);
  endtask

  // One uncontended transaction with literal strobe/done timing checks.
  task automatic do_txn(input int id, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd);
    bit ok;
    set_req(id, we, a, d);
    wait_gnt(id, ok);
    if (id == 0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
    rd = '0;
    if (ok) begin
      for (int k = 0; k < ACC; k++) begin
        if (k > 0) @(negedge clk);
        chk("txn_rf_read",  32'(bus.rf_read_o),  32'(!we));
        chk("txn_rf_write", 32'(bus.rf_write_o), 32'(we));
        chk("txn_rf_addr",  32'(bus.rf_addr_o),  32'(a));
        if (we) chk("txn_rf_wdata", bus.rf_wdata_o, d);
      end
      @(negedge clk);
      chk("txn_strobe_low", 32'(bus.rf_read_o | bus.rf_write_o), 32'd0);
      chk("txn_done", 32'((id == 0) ? bus.done0_o : bus.done1_o), 32'd1);
      rd = bus.rdata_o;
      @(negedge clk);
      chk("txn_done_pulse", 32'(bus.done0_o | bus.done1_o), 32'd0);
    end
  endtask

  initial begin : stim
    logic [DW-1:0] rd;
    logic g0, g1;
    bit ok;
    int both_hi, n_g1;

    for (int i = 0; i < 32; i++) begin
      rf_mem[i] <= '0;
      m_mem[i]   = '0;
    end
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    bus.we0_i  = 1'b0; bus.we1_i  = 1'b0;
    bus.addr0_i = '0;  bus.addr1_i = '0;
    bus.wdata0_i = '0; bus.wdata1_i = '0;
    rst = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_gnt",    32'(bus.gnt0_o | bus.gnt1_o),       32'd0);
    chk("rst_done",   32'(bus.done0_o | bus.done1_o),     32'd0);
    chk("rst_strobe", 32'(bus.rf_read_o | bus.rf_write_o), 32'd0);
    chk("rst_addr",   32'(bus.rf_addr_o), 32'd0);
    chk("rst_wdata",  bus.rf_wdata_o,     32'd0);
    chk("rst_rdata",  bus.rdata_o,        32'd0);
    rst = 1'b0;
    set_req(0, 1'b0, 5'd1, 32'd0);
    set_req(1, 1'b0, 5'd2, 32'd0);
    wait_any_gnt(g0, g1);
    chk("first_gnt0", 32'(g0), 32'd1);
    chk("first_gnt1", 32'(g1), 32'd0);
    bus.req0_i = 1'b0;
    wait_gnt(1, ok);
    bus.req1_i = 1'b0;
    repeat (4) @(negedge clk);

    // Write then read by requester 0.
    do_txn(0, 1'b1, 5'd5, 32'hDEADBEEF, rd);
    do_txn(0, 1'b0, 5'd5, 32'd0, rd);
    chk("wr_rd_rdata", rd, 32'hDEADBEEF);

    // Read result survives a later write.
    do_txn(0, 1'b1, 5'd9, 32'h000000AA, rd);
    do_txn(0, 1'b0, 5'd9, 32'd0, rd);
    chk("rd_aa", rd, 32'h000000AA);
    do_txn(1, 1'b1, 5'd3, 32'h00000055, rd);
    chk("rdata_kept_after_write", rd, 32'h000000AA);

    // Contention: both held for 16 cycles.
    gid_q.delete(); gcyc_q.delete();
    both_hi = 0;
    set_req(0, 1'b0, 5'd10, 32'd0);
    set_req(1, 1'b1, 5'd11, 32'h00000077);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.rf_read_o === 1'b1 && bus.rf_write_o === 1'b1) both_hi++;
    end
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    #1;
    chk("cont_grants", 32'(gid_q.size()), 32'd4);
    for (int i = 0; i < gid_q.size() && i < 4; i++) begin
      chk("cont_order", 32'(gid_q[i]), 32'(i % 2));
      if (i > 0) chk("cont_spacing", 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd4);
    end
    chk("cont_strobe_excl", 32'(both_hi), 32'd0);
    repeat (4) @(negedge clk);

    // Withdrawn request and request dropped after grant.
    set_req(0, 1'b0, 5'd4, 32'd0);
    wait_gnt(0, ok);
    bus.req0_i = 1'b0;
    set_req(1, 1'b0, 5'd6, 32'd0);
    chk("wd_addr_g", 32'(bus.rf_addr_o), 32'd4);
    @(negedge clk);
    bus.req1_i = 1'b0;
    chk("wd_addr_g1", 32'(bus.rf_addr_o), 32'd4);
    @(negedge clk);
    chk("wd_done0", 32'(bus.done0_o), 32'd1);
    chk("wd_addr_g2", 32'(bus.rf_addr_o), 32'd4);
    n_g1 = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.gnt1_o === 1'b1) n_g1++;
    end
    chk("wd_no_gnt1", 32'(n_g1), 32'd0);

    // Reset in the middle of a read.
    do_txn(1, 1'b1, 5'd7, 32'h12345678, rd);
    do_txn(1, 1'b0, 5'd7, 32'd0, rd);
    chk("pre_rst_rdata", rd, 32'h12345678);
    do_txn(0, 1'b1, 5'd8, 32'h0000BEEF, rd);
    chk("pre_rst_rdata_kept", rd, 32'h12345678);
    set_req(1, 1'b0, 5'd7, 32'd0);
    wait_gnt(1, ok);
    bus.req1_i = 1'b0;
    @(negedge clk);
    chk("abort_second_read", 32'(bus.rf_read_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_strobe", 32'(bus.rf_read_o | bus.rf_write_o), 32'd0);
    chk("abort_no_done1", 32'(bus.done1_o), 32'd0);
    chk("abort_rdata", bus.rdata_o, 32'd0);
    @(negedge clk);
    chk("abort_no_done1_later", 32'(bus.done1_o), 32'd0);
    set_req(0, 1'b0, 5'd1, 32'd0);
    set_req(1, 1'b0, 5'd2, 32'd0);
    wait_any_gnt(g0, g1);
    chk("post_rst_gnt0", 32'(g0), 32'd1);
    chk("post_rst_gnt1", 32'(g1), 32'd0);
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
